// File: rtl/apresentador_indices.sv
// apresentador_indices: shows up to four captured 2-bit indices as one-hot LED pulses,
// each lit for T_ACESO cycles and followed by a T_APAGADO dark gap.
`default_nettype none

module apresentador_indices #(
  parameter int T_ACESO   = 25000000,
  parameter int T_APAGADO = 12500000,
  parameter int N_PASSOS  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] indices,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado,
  output logic [1:0] db_passo
);

  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] ULT_ACESO   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] ULT_APAGADO = TW'(T_APAGADO - 1);
  localparam logic [1:0]    ULT_PASSO   = 2'(N_PASSOS - 1);

  typedef enum logic [1:0] {
    INICIAL = 2'd0,
    ACESO   = 2'd1,
    APAGADO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    passo_q, passo_d;
  logic [7:0]    captura_q, captura_d;
  logic [3:0]    leds_q, leds_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= INICIAL;
      timer_q   <= '0;
      passo_q   <= '0;
      captura_q <= '0;
      leds_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      passo_q   <= passo_d;
      captura_q <= captura_d;
      leds_q    <= leds_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q;
    passo_d   = passo_q;
    captura_d = captura_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          captura_d = indices;
          passo_d   = '0;
          timer_d   = '0;
          estado_d  = ACESO;
        end
      end
      ACESO: begin
        if (timer_q == ULT_ACESO) begin
          timer_d  = '0;
          estado_d = APAGADO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGADO: begin
        if (timer_q == ULT_APAGADO) begin
          timer_d = '0;
          if (passo_q == ULT_PASSO) begin
            estado_d = FIM;
          end else begin
            passo_d  = passo_q + 1'b1;
            estado_d = ACESO;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FIM:     estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase
  end

  // LED register is loaded from next-state values so it lines up with the state register.
  always_comb begin
    leds_d = '0;
    if (estado_d == ACESO) begin
      leds_d = 4'b0001 << captura_d[{passo_d, 1'b0} +: 2];
    end
  end

  assign leds      = leds_q;
  assign ocupado   = (estado_q == ACESO) || (estado_q == APAGADO);
  assign pronto    = (estado_q == FIM);
  assign db_estado = {2'b00, estado_q};
  assign db_passo  = passo_q;

endmodule

`default_nettype wire

// File: tb/tb_apresentador_indices.sv
// Bench for apresentador_indices: a 4-step and a 1-step instance driven in parallel,
// compared each cycle against an arithmetic round-timeline model.
`default_nettype none

module tb_apresentador_indices;

  localparam int TA = 3;
  localparam int TP = 2;
  localparam int P  = TA + TP;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [7:0] indices;

  logic [3:0] leds   [2];
  logic       ocup   [2];
  logic       pronto [2];
  logic [3:0] estado [2];
  logic [1:0] passo  [2];

  int errors = 0;
  int checks = 0;

  // Model: a round is "busy" for offsets k = 0 .. N*P, offset N*P being FIM.
  bit   m_busy [2];
  int   m_k    [2];
  logic [7:0] m_cap [2];

  always #5 clock = ~clock;

  apresentador_indices #(.T_ACESO(TA), .T_APAGADO(TP), .N_PASSOS(4)) u_dut4 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .indices(indices),
    .leds(leds[0]), .ocupado(ocup[0]), .pronto(pronto[0]),
    .db_estado(estado[0]), .db_passo(passo[0])
  );

  apresentador_indices #(.T_ACESO(TA), .T_APAGADO(TP), .N_PASSOS(1)) u_dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .indices(indices),
    .leds(leds[1]), .ocupado(ocup[1]), .pronto(pronto[1]),
    .db_estado(estado[1]), .db_passo(passo[1])
  );

  function automatic int n_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(string tag, int i, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[n=%0d] observed=%0h expected=%0h", tag, n_of(i), obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] el;
      logic       eo, ep;
      logic [3:0] es;
      int         st, len;
      len = n_of(i) * P;
      el = 4'b0000; eo = 1'b0; ep = 1'b0; es = 4'd0; st = -1;
      if (m_busy[i]) begin
        if (m_k[i] == len) begin
          es = 4'd3; ep = 1'b1; st = n_of(i) - 1;
        end else begin
          st = m_k[i] / P;
          eo = 1'b1;
          if ((m_k[i] % P) < TA) begin
            es = 4'd1;
            el = 4'(1 << m_cap[i][2*st +: 2]);
          end else begin
            es = 4'd2;
          end
        end
      end
      check("leds", i, 8'(leds[i]), 8'(el));
      check("ocupado", i, 8'(ocup[i]), 8'(eo));
      check("pronto", i, 8'(pronto[i]), 8'(ep));
      check("db_estado", i, 8'(estado[i]), 8'(es));
      if (st >= 0) check("db_passo", i, 8'(passo[i]), 8'(st));
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (iniciar) begin
          m_busy[i] = 1'b1;
          m_k[i]    = 0;
          m_cap[i]  = indices;
        end
      end else if (m_k[i] == n_of(i) * P) begin
        m_busy[i] = 1'b0;
      end else begin
        m_k[i]++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic round(logic [7:0] idx, int tail);
    indices = idx;
    iniciar = 1'b1;
    cycle();
    iniciar = 1'b0;
    repeat (tail) cycle();
  endtask

  initial begin
    int guard;
    reset   = 1'b1;
    iniciar = 1'b0;
    indices = 8'h00;
    m_busy  = '{default: 1'b0};
    m_k     = '{default: 0};
    m_cap   = '{default: 8'h00};

    repeat (2) cycle();
    for (int i = 0; i < 2; i++) check("reset_passo", i, 8'(passo[i]), 8'd0);
    reset = 1'b0;
    repeat (2) cycle();

    // Full round with distinct indices
    round(8'b11100100, 24);

    // Capture isolation: indices cleared before edge e2
    indices = 8'b11100100;
    iniciar = 1'b1;
    cycle();
    iniciar = 1'b0;
    cycle();
    indices = 8'b00000000;
    repeat (24) cycle();

    // Start held high across the whole round and beyond
    indices = 8'b00011011;
    iniciar = 1'b1;
    repeat (30) cycle();
    iniciar = 1'b0;
    repeat (25) cycle();

    // Repeated index and the single-step instance's 2'b10 case
    round(8'b01010101, 24);
    round(8'b00000010, 24);

    // Asynchronous reset during step 2 ACESO
    round(8'b11100100, 0);
    guard = 0;
    while (!(m_busy[0] && m_k[0] == 2 * P + 1) && guard < 50) begin
      cycle();
      guard++;
    end
    checks++;
    assert (guard < 50) else begin
      errors++;
      $error("FAIL reset_mid_wait observed=timeout expected=step2");
    end
    reset = 1'b1;
    m_busy = '{default: 1'b0};
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_leds", i, 8'(leds[i]), 8'd0);
      check("async_estado", i, 8'(estado[i]), 8'd0);
      check("async_passo", i, 8'(passo[i]), 8'd0);
    end
    cycle();
    reset = 1'b0;
    repeat (25) cycle();

    // Randomized start pulses, indices and occasional resets
    for (int n = 0; n < 400; n++) begin
      iniciar = ($urandom_range(0, 5) == 0);
      indices = 8'($urandom);
      reset   = ($urandom_range(0, 120) == 0);
      cycle();
    end
    reset   = 1'b0;
    iniciar = 1'b0;
    repeat (25) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apresentador_indices.md
APRESENTADOR_INDICES -- requirements
Module: apresentador_indices

Interface
REQ-001 Parameter T_ACESO, default 25000000, LED-on duration per step in clock cycles; legal range >= 1.
REQ-002 Parameter T_APAGADO, default 12500000, LED-off gap after each step in clock cycles; legal range >= 1.
REQ-003 Parameter N_PASSOS, default 4, number of indices presented per round; legal range 1..4.
REQ-004 clock  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 iniciar  input  1  start request; sampled only in state INICIAL.
REQ-007 indices  input  8  four packed 2-bit indices; step k uses indices[2k+1:2k].
REQ-008 leds  output  4  registered one-hot LED drive to the player; 4'b0000 when dark.
REQ-009 ocupado  output  1  high while in ACESO or APAGADO.
REQ-010 pronto  output  1  high for exactly one cycle, in state FIM.
REQ-011 db_estado  output  4  current state code: INICIAL=0, ACESO=1, APAGADO=2, FIM=3.
REQ-012 db_passo  output  2  current step index.

Function
REQ-013 States SHALL be INICIAL, ACESO, APAGADO and FIM only; any unused encoding SHALL go to INICIAL on the next edge.
REQ-014 In INICIAL with iniciar=1 at an edge, the block SHALL capture indices into an internal register, clear step and timer, and enter ACESO.
REQ-015 Changes on indices after capture SHALL NOT affect the round in progress.
REQ-016 In ACESO, leds SHALL equal 4'b0001 shifted left by the captured 2-bit field of the current step (00->0001, 01->0010, 10->0100, 11->1000).
REQ-017 ACESO SHALL last exactly T_ACESO cycles, then the block SHALL enter APAGADO with a cleared timer.
REQ-018 In APAGADO, leds SHALL be 4'b0000, and the state SHALL last exactly T_APAGADO cycles.
REQ-019 At the end of APAGADO, if step = N_PASSOS-1 the block SHALL enter FIM; otherwise step SHALL increment by 1 and the block SHALL enter ACESO.
REQ-020 FIM SHALL last one cycle with pronto=1 and leds=0, then return to INICIAL unconditionally.
REQ-021 iniciar SHALL be ignored in ACESO, APAGADO and FIM; no restart and no re-capture.
REQ-022 A start accepted at edge e0 SHALL put the block in FIM after edge e0 + N_PASSOS*(T_ACESO+T_APAGADO).
REQ-023 The timer SHALL be wide enough for max(T_ACESO, T_APAGADO) and SHALL never wrap within a state.
REQ-024 Step SHALL never exceed N_PASSOS-1.
REQ-025 Identical consecutive indices SHALL still produce separate pulses, separated by the APAGADO gap.
REQ-026 Outside ACESO, leds SHALL be 4'b0000; in INICIAL, ocupado and pronto SHALL be 0.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force state INICIAL, step 0, timer 0, captured register 0, leds 4'b0000, ocupado 0, pronto 0, db_estado 0, db_passo 0.
REQ-028 reset asserted mid-round SHALL abort the round with no pronto pulse.
REQ-029 After reset releases, the next round SHALL require a new iniciar in INICIAL.

Verification (T_ACESO=3, T_APAGADO=2, N_PASSOS=4 unless stated)
REQ-030 Full round, indices=8'b11100100, 1-cycle iniciar at e0:
  - leds = 0001, 0010, 0100, 1000, each for 3 cycles;
  - 2 dark cycles after each pulse;
  - pronto=1 only after edge e20, with ocupado=1 throughout e1..e20.
REQ-031 Capture isolation: indices change to 8'b00000000 at e2 -> sequence still 0001, 0010, 0100, 1000.
REQ-032 Ignored start: iniciar held high for the whole round -> no restart during the round; a new round starts on the edge after FIM.
REQ-033 Repeated index, indices=8'b01010101 -> four separate 0010 pulses, each 3 cycles, separated by 2 cycles of 0000.
REQ-034 Reset mid-round: reset asserted during step 2 ACESO -> leds=0000 and db_estado=0 with no clock edge; no pronto pulse follows.
REQ-035 N_PASSOS=1, indices[1:0]=2'b10 -> leds 0100 for 3 cycles, 0000 for 2 cycles, then pronto for 1 cycle, then db_estado=0.
